// File: rtl/cnn_pool_pkg.sv
// Shared types, sizes and arithmetic helpers for the global average-pool stage
// that reduces the 128-channel 4x4 max-pool output to one value per channel.
package cnn_pool_pkg;

    localparam int N_CH     = 128;
    localparam int PIX      = 16;
    localparam int PIX_LOG2 = 4;
    localparam int DW       = 4;
    localparam int ACC_W    = 8;
    localparam int TOTAL    = N_CH * PIX;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP_START = 3'd1,
        WAIT_UP  = 3'd2,
        ACCUM    = 3'd3,
        FINISH   = 3'd4
    } gap_state_t;

    // Round-half-up mean of PIX samples: (acc + PIX/2) >> log2(PIX).
    // The largest sum is 240, so the 8-bit addition cannot wrap and the
    // result always fits in DW bits.
    function automatic logic [DW-1:0] avg_round(input logic [ACC_W-1:0] acc);
        return DW'((acc + ACC_W'(PIX / 2)) >> PIX_LOG2);
    endfunction

endpackage

// File: rtl/global_avgpool_4x4_128ch_if.sv
// Link between the average-pool block and the upstream max-pool stage:
// start/done handshake plus the read port into the max-pool output buffer.
interface global_avgpool_4x4_128ch_if;
    logic        up_start;
    logic        up_done;
    logic [31:0] up_read_addr;
    logic [3:0]  up_read_data;

    modport master (
        output up_start,
        output up_read_addr,
        input  up_done,
        input  up_read_data
    );

    modport slave (
        input  up_start,
        input  up_read_addr,
        output up_done,
        output up_read_data
    );
endinterface

// File: rtl/gap_result_regfile.sv
// 128 x 4-bit result store: one synchronous write port, asynchronous clear,
// combinational read that returns 0 for any index past the last channel.
module gap_result_regfile
    import cnn_pool_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [6:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [31:0]   raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [N_CH];

    // Result storage: cleared on reset, one channel written per last-pixel sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_CH; i++) begin
                mem_r[i] <= 4'd0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Random-access read; indices beyond the channel count read as zero.
    always_comb begin
        rdata = 4'd0;
        if (raddr < 32'(N_CH)) begin
            rdata = mem_r[raddr[6:0]];
        end else begin
            rdata = 4'd0;
        end
    end

endmodule

// File: rtl/global_avgpool_4x4_128ch.sv
// Global average pool over a 128-channel 4x4 map of 4-bit activations.
// Kicks the upstream max-pool stage, streams all 2048 activations out of its
// buffer at one address per cycle, and stores a rounded mean per channel.
module global_avgpool_4x4_128ch
    import cnn_pool_pkg::*;
#(
    parameter int UP_LAT = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [31:0]                   read_addr,
    output logic [DW-1:0]                 read_data,
    output logic                          done,
    global_avgpool_4x4_128ch_if.master    up
);

    gap_state_t          state_r;
    gap_state_t          state_s;
    logic                up_start_r;
    logic                done_r;
    logic [10:0]         issue_cnt_r;
    logic                issue_done_r;
    logic [UP_LAT-1:0]   vld_pipe_r;
    logic [10:0]         addr_pipe_r [UP_LAT];
    logic [ACC_W-1:0]    acc_r;

    logic                issue_vld_s;
    logic                smp_vld_s;
    logic [10:0]         smp_addr_s;
    logic                smp_last_s;
    logic [ACC_W-1:0]    sum_s;
    logic                we_s;

    assign up.up_start     = up_start_r;
    assign up.up_read_addr = {21'd0, issue_cnt_r};
    assign done            = done_r;

    // Next-state logic for the run sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = UP_START;
                else       state_s = IDLE;
            end
            UP_START: state_s = WAIT_UP;
            WAIT_UP: begin
                if (up.up_done) state_s = ACCUM;
                else            state_s = WAIT_UP;
            end
            ACCUM: begin
                if (smp_vld_s && (smp_addr_s == 11'(TOTAL - 1))) state_s = FINISH;
                else                                              state_s = ACCUM;
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sample-side datapath: the oldest delay-line entry tags the incoming
    // activation; pixel 0 starts a fresh sum so channels run back to back.
    always_comb begin
        issue_vld_s = (state_r == ACCUM) && !issue_done_r;
        smp_vld_s   = vld_pipe_r[UP_LAT-1];
        smp_addr_s  = addr_pipe_r[UP_LAT-1];
        smp_last_s  = (smp_addr_s[3:0] == 4'hF);
        if (smp_addr_s[3:0] == 4'h0) begin
            sum_s = {4'd0, up.up_read_data};
        end else begin
            sum_s = acc_r + {4'd0, up.up_read_data};
        end
        we_s = smp_vld_s && smp_last_s;
    end

    // State register with the registered one-cycle up_start and done pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            up_start_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            up_start_r <= (state_s == UP_START);
            done_r     <= (state_s == FINISH);
        end
    end

    // Issue counter: reloaded when upstream completes, then one address per
    // cycle until the last one has been issued, where it parks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            issue_cnt_r  <= 11'd0;
            issue_done_r <= 1'b0;
        end else if ((state_r == WAIT_UP) && up.up_done) begin
            issue_cnt_r  <= 11'd0;
            issue_done_r <= 1'b0;
        end else if (issue_vld_s) begin
            if (issue_cnt_r == 11'(TOTAL - 1)) begin
                issue_done_r <= 1'b1;
            end else begin
                issue_cnt_r <= issue_cnt_r + 11'd1;
            end
        end
    end

    // Delay line matching the upstream read latency: valid bit plus address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe_r <= {UP_LAT{1'b0}};
            for (int i = 0; i < UP_LAT; i++) begin
                addr_pipe_r[i] <= 11'd0;
            end
        end else begin
            vld_pipe_r[0]  <= issue_vld_s;
            addr_pipe_r[0] <= issue_cnt_r;
            for (int i = 1; i < UP_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                addr_pipe_r[i] <= addr_pipe_r[i-1];
            end
        end
    end

    // Per-channel accumulator, emptied after each channel's last pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r <= 8'd0;
        end else if (smp_vld_s) begin
            acc_r <= smp_last_s ? 8'd0 : sum_s;
        end
    end

    gap_result_regfile u_regfile (
        .clk    (clk),
        .resetn (resetn),
        .we     (we_s),
        .waddr  (smp_addr_s[10:4]),
        .wdata  (avg_round(sum_s)),
        .raddr  (read_addr),
        .rdata  (read_data)
    );

endmodule

// File: tb/tb_global_avgpool_4x4_128ch.sv
// Randomised self-checking bench for global_avgpool_4x4_128ch. A latency-1 and
// a latency-2 instance each talk to a small upstream buffer model; expected
// results come from plain per-channel sums of the stimulus pattern.
module tb_global_avgpool_4x4_128ch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start, start2;
    logic [31:0] read_addr, read_addr2;
    logic [3:0]  read_data, read_data2;
    logic        done, done2;

    global_avgpool_4x4_128ch_if up0 ();
    global_avgpool_4x4_128ch_if up1 ();

    global_avgpool_4x4_128ch #(.UP_LAT(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .read_addr(read_addr),
        .read_data(read_data), .done(done), .up(up0)
    );

    global_avgpool_4x4_128ch #(.UP_LAT(2)) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .read_addr(read_addr2),
        .read_data(read_data2), .done(done2), .up(up1)
    );

    always #5 clk = ~clk;

    // Stimulus pattern, expected results, upstream model state, monitors.
    logic [3:0] pat [2048];
    int         exp_res [128];
    int         done_dly = 3;
    int         cd0 = 0, cd1 = 0;
    logic [3:0] d0, d1a, d1b;
    int         cyc = 0;
    int         c0_0 = 0, c0_1 = 0;
    int         ndone0 = 0, ndone1 = 0, nups0 = 0, nups1 = 0;
    int         dcyc0 = 0, dcyc1 = 0;
    int         n_chk = 0, n_pass = 0;

    assign up0.up_done      = (cd0 == 1);
    assign up0.up_read_data = d0;
    assign up1.up_done      = (cd1 == 1);
    assign up1.up_read_data = d1b;

    // Upstream buffer models (1- and 2-cycle read latency) and done timers.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        d0  <= pat[up0.up_read_addr[10:0]];
        d1a <= pat[up1.up_read_addr[10:0]];
        d1b <= d1a;
        if (up0.up_start) cd0 <= done_dly; else if (cd0 != 0) cd0 <= cd0 - 1;
        if (up1.up_start) cd1 <= done_dly; else if (cd1 != 0) cd1 <= cd1 - 1;
        if (up0.up_done) c0_0 <= cyc;
        if (up1.up_done) c0_1 <= cyc;
    end

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (done)         begin ndone0 <= ndone0 + 1; dcyc0 <= cyc; end
        if (done2)        begin ndone1 <= ndone1 + 1; dcyc1 <= cyc; end
        if (up0.up_start) nups0 <= nups0 + 1;
        if (up1.up_start) nups1 <= nups1 + 1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: rounded mean of each channel's 16 pixels.
    task automatic build_model();
        for (int ch = 0; ch < 128; ch++) begin
            int s = 0;
            for (int p = 0; p < 16; p++) s += int'(pat[ch*16 + p]);
            exp_res[ch] = (s + 8) / 16;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 2048; a++) pat[a] = 4'($urandom_range(15, 0));
    endtask

    task automatic sweep(input int which, input string tag);
        for (int ch = 0; ch < 128; ch++) begin
            if (which == 0) begin read_addr = ch; #1; chk($sformatf("%s[%0d]", tag, ch), read_data, exp_res[ch]); end
            else begin read_addr2 = ch; #1; chk($sformatf("%s[%0d]", tag, ch), read_data2, exp_res[ch]); end
        end
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic run_layer(input int which);
        int  nd, nu;
        bit  seen;
        nd = (which == 0) ? ndone0 : ndone1;
        nu = (which == 0) ? nups0 : nups1;
        pulse_start(which);
        seen = 1'b0;
        for (int t = 0; t < 4000 && !seen; t++) begin
            @(negedge clk);
            seen = (which == 0) ? done : done2;
        end
        chk("done_seen", seen, 1);
        repeat (4) @(negedge clk);
        if (which == 0) begin
            chk("done_cnt", ndone0 - nd, 1);
            chk("upstart_cycles", nups0 - nu, 1);
            chk("done_cyc", dcyc0, c0_0 + 2050);
        end else begin
            chk("done_cnt_lat2", ndone1 - nd, 1);
            chk("upstart_cycles_lat2", nups1 - nu, 1);
            chk("done_cyc_lat2", dcyc1, c0_1 + 2051);
        end
    endtask

    initial begin
        int  nd, nu, c0;
        bit  seen;
        resetn = 1'b0; start = 1'b0; start2 = 1'b0;
        read_addr = 32'd0; read_addr2 = 32'd0;
        for (int a = 0; a < 2048; a++) pat[a] = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_up_start", up0.up_start, 0);
        chk("rst_up_addr", up0.up_read_addr, 0);
        chk("rst_read", read_data, 0);
        resetn = 1'b1;
        @(negedge clk);

        // All-15 map.
        for (int a = 0; a < 2048; a++) pat[a] = 4'd15;
        build_model();
        run_layer(0);
        sweep(0, "all15");

        // Rounding boundaries on channels 3..5, random elsewhere.
        fill_random();
        for (int p = 0; p < 16; p++) begin
            pat[48 + p] = (p < 7) ? 4'd1 : 4'd0;
            pat[64 + p] = (p < 8) ? 4'd1 : 4'd0;
            pat[80 + p] = 4'(p);
        end
        build_model();
        run_layer(0);
        read_addr = 32'd3; #1; chk("sum7_rounds_to_0", read_data, 0);
        read_addr = 32'd4; #1; chk("sum8_rounds_to_1", read_data, 1);
        read_addr = 32'd5; #1; chk("sum120_rounds_to_8", read_data, 8);
        sweep(0, "round");

        // Channel-index pattern and out-of-range reads.
        for (int a = 0; a < 2048; a++) pat[a] = 4'((a / 16) % 16);
        build_model();
        run_layer(0);
        sweep(0, "chmod16");
        read_addr = 32'd128;        #1; chk("oor_128", read_data, 0);
        read_addr = 32'hFFFF_FFFF;  #1; chk("oor_max", read_data, 0);

        // Reset in the middle of accumulation aborts the run.
        fill_random();
        nd = ndone0;
        pulse_start(0);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = up0.up_done;
        end
        chk("abort_up_done_seen", seen, 1);
        repeat (500) @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2200) @(negedge clk);
        chk("abort_no_done", ndone0 - nd, 0);
        for (int ch = 0; ch < 128; ch++) exp_res[ch] = 0;
        sweep(0, "cleared");
        fill_random();
        build_model();
        run_layer(0);
        sweep(0, "after_abort");

        // Stray starts in WAIT_UP, ACCUM and FINISH are ignored.
        fill_random();
        build_model();
        done_dly = 8;
        nd = ndone0; nu = nups0;
        pulse_start(0);
        repeat (2) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = up0.up_done;
        end
        c0 = cyc;
        repeat (100) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 4000 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        chk("stray_done_seen", seen, 1);
        chk("stray_done_cnt", ndone0 - nd, 1);
        chk("stray_upstart_cnt", nups0 - nu, 1);
        chk("stray_done_cyc", dcyc0, c0 + 2050);
        sweep(0, "stray");
        fill_random();
        build_model();
        done_dly = 3;
        run_layer(0);
        sweep(0, "second_run");

        // Latency-2 upstream.
        for (int a = 0; a < 2048; a++) pat[a] = 4'd15;
        build_model();
        run_layer(1);
        sweep(1, "lat2_all15");
        fill_random();
        build_model();
        run_layer(1);
        sweep(1, "lat2_rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/global_avgpool_4x4_128ch.md
Name: global_avgpool_4x4_128ch

Overview:
Downstream neighbour of the third 2x2 max-pool stage in the CIFAR-10 CNN. Once the max-pool stage reports done, this block reads its 128-channel 4x4 feature map of 4-bit activations and reduces each channel to one rounded 4-bit mean. It stores the 128 results in an internal register file and exposes them through a random-access read port for the classifier head.

Parameters:
N_CH, 128, number of channels.
PIX, 16, pixels per channel (4x4); fixed power of two, log2 = 4.
DW, 4, activation width in bits.
UP_LAT, 1, cycles from presenting up_read_addr to up_read_data being valid (BRAM port-B latency).

Ports:
clk  in  1  single clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to run the layer.
read_addr  in  32  result index, channel 0..N_CH-1.
read_data  out  4  averaged activation for read_addr.
done  out  1  one-cycle pulse when all results are valid.
up_start  out  1  one-cycle start pulse to the max-pool stage.
up_done  in  1  max-pool stage completion pulse.
up_read_addr  out  32  flat index into the max-pool output, ch*16 + row*4 + col.
up_read_data  in  4  max-pool activation.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; done=0, up_start=0, up_read_addr=0; accumulator, counters and pipeline valids cleared; all 128 results cleared to 0. Reset asserted mid-run aborts the run immediately. No partial done is produced.
- States: IDLE -> UP_START -> WAIT_UP -> ACCUM -> FINISH -> IDLE.
- IDLE: start=1 -> up_start=1 next cycle, go to UP_START. start in any other state is ignored (no restart, no queueing).
- UP_START: up_start returns to 0, so the pulse is exactly 1 cycle. Go to WAIT_UP.
- WAIT_UP: hold until up_done=1, sampled in cycle c0. Load the issue counter to 0 and go to ACCUM.
- ACCUM: up_read_addr equals the issue counter; address 0 is presented in cycle c0+1.
  - The counter increments by 1 each cycle through N_CH*PIX-1 = 2047 (no stalls).
  - A UP_LAT-deep valid/last-pixel delay line accompanies each address.
  - Data for the address presented in cycle k is sampled in cycle k+UP_LAT.
  - On each valid sample, acc += up_read_data. acc is 8 bits; the maximum is 16*15 = 240, so it never overflows.
  - On the sample of pixel 15 of channel ch: result[ch] = (acc_total + 8) >> 4, which is round-half-up and always ≤ 15. acc restarts at 0 for the next channel, and the sample of the next channel's pixel 0 loads acc directly, with no bubble.
  - The issue counter saturates at 2047 and stops advancing once the last address has been issued.
- FINISH is entered on the edge that writes result[127], which is the end of cycle c0+2048+UP_LAT. done=1 for exactly one cycle, c0+2049+UP_LAT, then the block returns to IDLE.
- Read port:
  - read_data is combinational from read_addr: result[read_addr[6:0]] when read_addr < N_CH, else 0.
  - Results stay valid until overwritten by the next run. During a run, a channel's entry changes on the cycle after its last pixel is sampled.
- up_read_data is only consumed while a delay-line valid bit is set. Values outside ACCUM are ignored.
- A second start arriving in the same cycle as done (state FINISH) is ignored. The caller must re-issue it in IDLE.

Decomposition:
- Package cnn_pool_pkg:
  - gap_state_t enum (IDLE, UP_START, WAIT_UP, ACCUM, FINISH);
  - localparams N_CH=128, PIX=16, PIX_LOG2=4, DW=4, ACC_W=8, TOTAL=N_CH*PIX;
  - round-shift helper function avg_round(acc).
- One sub-module, gap_result_regfile: 128x4 register array with a synchronous write port (we, waddr[6:0], wdata), asynchronous clear on resetn, and a combinational read port with out-of-range zeroing.

Test Plan:
- Upstream model returns 15 for all 2048 addresses -> up_start is a 1-cycle pulse; done is high exactly at c0+2049+UP_LAT; read_addr 0..127 all return 15.
- Channel 3 has pixel values summing to 7 (seven 1s, rest 0) and channel 4 sums to 8 -> result[3]=0, result[4]=1. Channel 5 = values 0..15 (sum 120) -> (128>>4)=8.
- data = (ch mod 16) for every pixel of ch -> result[ch] = ch mod 16. read_addr=128 and read_addr=32'hFFFF_FFFF -> read_data=0.
- resetn dropped at c0+500 during ACCUM, then a fresh start after release -> no done from the aborted run; all results read 0 before the new run; the new run completes normally with correct values.
- start pulsed during WAIT_UP and during ACCUM -> no extra up_start, issue counter undisturbed, exactly one done; a start in IDLE after done begins a second run.
- UP_LAT=2 build with the all-15 stimulus -> done at c0+2051; every value sampled with the correct address alignment (checked with a per-address-unique pattern).
